div_exec_unit: RTL

- Iterative radix-2 divider; the execution unit behind the div issue queue.
- Acts as responder to issue_unit: accepts an operand packet on issue_div and drives div_exec_ready.
- Returns the result as a cdb_bus packet to cdb_logic on its CDB_Div input.
- Fixed latency, so issue_unit can reserve the CDB slot in advance.

---
 rtl/div_exec_unit_pkg.sv | 28 ++
 rtl/div_exec_unit_if.sv | 23 ++
 rtl/div_exec_unit_div_step.sv | 30 +++
 rtl/div_exec_unit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/div_exec_unit_pkg.sv
// rtl/div_exec_unit_pkg.sv - shared types and constants for the divide execution unit
package div_exec_unit_pkg;

   localparam int DIV_DATA_WIDTH = 32;
   localparam int DIV_TAG_WIDTH  = 6;
   localparam int DIV_LATENCY    = DIV_DATA_WIDTH + 2;

   localparam logic [2:0] F3_DIV  = 3'b100;
   localparam logic [2:0] F3_DIVU = 3'b101;
   localparam logic [2:0] F3_REM  = 3'b110;
   localparam logic [2:0] F3_REMU = 3'b111;

   typedef struct packed {
      logic [DIV_TAG_WIDTH-1:0]  cdb_tag;
      logic [DIV_DATA_WIDTH-1:0] cdb_data;
      logic                      cdb_valid;
      logic                      cdb_branch;
      logic                      cdb_branch_taken;
   } cdb_bus;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      ITER,
      DONE
   } div_state_t;

endpackage

// File: rtl/div_exec_unit_if.sv
// rtl/div_exec_unit_if.sv - issue/CDB signal bundle between issue_unit and the divider
interface div_exec_unit_if;
   import div_exec_unit_pkg::*;

   logic                      issue_div;
   logic [DIV_DATA_WIDTH-1:0] rs_data;
   logic [DIV_DATA_WIDTH-1:0] rt_data;
   logic [DIV_TAG_WIDTH-1:0]  rd_tag;
   logic [2:0]                funct3;
   logic                      div_exec_ready;
   cdb_bus                    cdb_div;

   modport master (
      output issue_div, rs_data, rt_data, rd_tag, funct3,
      input  div_exec_ready, cdb_div
   );

   modport slave (
      input  issue_div, rs_data, rt_data, rd_tag, funct3,
      output div_exec_ready, cdb_div
   );

endinterface

// File: rtl/div_exec_unit_div_step.sv
// rtl/div_exec_unit_div_step.sv - one combinational restoring-division iteration
module div_step
   import div_exec_unit_pkg::*;
#(
   parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] rem_i,
   input  logic [DATA_WIDTH-1:0] quo_i,
   input  logic [DATA_WIDTH-1:0] divisor_i,
   output logic [DATA_WIDTH-1:0] rem_o,
   output logic [DATA_WIDTH-1:0] quo_o
);

   logic [DATA_WIDTH:0] rem_sh;
   logic [DATA_WIDTH:0] diff;

   // rem < divisor always holds, so the shifted value fits in DATA_WIDTH+1 bits
   assign rem_sh = {rem_i, quo_i[DATA_WIDTH-1]};
   assign diff   = rem_sh - {1'b0, divisor_i};

   always_comb begin
      rem_o = rem_sh[DATA_WIDTH-1:0];
      quo_o = {quo_i[DATA_WIDTH-2:0], 1'b0};
      if (!diff[DATA_WIDTH]) begin
         rem_o = diff[DATA_WIDTH-1:0];
         quo_o = {quo_i[DATA_WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/div_exec_unit.sv
// rtl/div_exec_unit.sv - fixed-latency radix-2 divider returning results on the CDB
// Optional DIV_FLUSH_EN adds a flush input that aborts the in-flight operation.
module div_exec_unit
   import div_exec_unit_pkg::*;
#(
   parameter int DATA_WIDTH = DIV_DATA_WIDTH,
   parameter int TAG_WIDTH  = DIV_TAG_WIDTH
) (
   input  logic           clk,
   input  logic           rst,
`ifdef DIV_FLUSH_EN
   input  logic           flush,
`endif
   div_exec_unit_if.slave div_if
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);

   div_state_t            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rem_q, rem_d;
   logic [DATA_WIDTH-1:0] quo_q, quo_d;
   logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
   logic [TAG_WIDTH-1:0]  tag_q, tag_d;
   logic [1:0]            f3_q, f3_d;
   logic                  q_neg_q, q_neg_d;
   logic                  r_neg_q, r_neg_d;
   logic [DATA_WIDTH-1:0] cdb_data_q, cdb_data_d;
   logic [TAG_WIDTH-1:0]  cdb_tag_q, cdb_tag_d;

   logic                  flush_w;
   logic                  cdb_valid_w;
   logic                  sgn, rs_neg, rt_neg, div_zero;
   logic [DATA_WIDTH-1:0] step_rem, step_quo;
   logic [DATA_WIDTH-1:0] quo_fix, rem_fix, result_w;

`ifdef DIV_FLUSH_EN
   assign flush_w = flush;
`else
   assign flush_w = 1'b0;
`endif

   // In LOAD quo_q/dvs_q still hold the raw operands captured in IDLE
   assign sgn      = ~f3_q[0];
   assign rs_neg   = sgn & quo_q[DATA_WIDTH-1];
   assign rt_neg   = sgn & dvs_q[DATA_WIDTH-1];
   assign div_zero = (dvs_q == '0);

   assign quo_fix  = q_neg_q ? -quo_q : quo_q;
   assign rem_fix  = r_neg_q ? -rem_q : rem_q;
   assign result_w = f3_q[1] ? rem_fix : quo_fix;

   div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
      .rem_i     (rem_q),
      .quo_i     (quo_q),
      .divisor_i (dvs_q),
      .rem_o     (step_rem),
      .quo_o     (step_quo)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      tag_d       = tag_q;
      f3_d        = f3_q;
      q_neg_d     = q_neg_q;
      r_neg_d     = r_neg_q;
      cdb_data_d  = cdb_data_q;
      cdb_tag_d   = cdb_tag_q;
      cdb_valid_w = 1'b0;
      case (state_q)
         IDLE: begin
            if (div_if.issue_div) begin
               quo_d   = div_if.rs_data;
               dvs_d   = div_if.rt_data;
               tag_d   = div_if.rd_tag;
               f3_d    = div_if.funct3[1:0];
               state_d = LOAD;
            end
         end
         LOAD: begin
            quo_d   = rs_neg ? -quo_q : quo_q;
            dvs_d   = rt_neg ? -dvs_q : dvs_q;
            // Divide-by-zero must return all ones even for a negative dividend
            q_neg_d = (rs_neg ^ rt_neg) & ~div_zero;
            r_neg_d = rs_neg;
            rem_d   = '0;
            cnt_d   = CNT_W'(DATA_WIDTH);
            state_d = ITER;
         end
         ITER: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            cdb_valid_w = 1'b1;
            cdb_data_d  = result_w;
            cdb_tag_d   = tag_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush_w) begin
         state_d     = IDLE;
         cdb_valid_w = 1'b0;
         cdb_data_d  = cdb_data_q;
         cdb_tag_d   = cdb_tag_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         dvs_q      <= '0;
         tag_q      <= '0;
         f3_q       <= '0;
         q_neg_q    <= 1'b0;
         r_neg_q    <= 1'b0;
         cdb_data_q <= '0;
         cdb_tag_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         dvs_q      <= dvs_d;
         tag_q      <= tag_d;
         f3_q       <= f3_d;
         q_neg_q    <= q_neg_d;
         r_neg_q    <= r_neg_d;
         cdb_data_q <= cdb_data_d;
         cdb_tag_q  <= cdb_tag_d;
      end
   end

   assign div_if.div_exec_ready            = (state_q == IDLE);
   assign div_if.cdb_div.cdb_valid         = cdb_valid_w;
   assign div_if.cdb_div.cdb_data          = cdb_valid_w ? result_w : cdb_data_q;
   assign div_if.cdb_div.cdb_tag           = cdb_valid_w ? tag_q : cdb_tag_q;
   assign div_if.cdb_div.cdb_branch        = 1'b0;
   assign div_if.cdb_div.cdb_branch_taken  = 1'b0;

`ifndef SYNTHESIS
   always @(posedge clk) begin
      assert (rst || !(div_if.issue_div && state_q != IDLE))
         else $warning("div_exec_unit: issue_div while busy, request ignored");
   end
`endif

endmodule
